// File: rtl/ro_meter_pkg.sv
// Shared definitions for the ring-oscillator frequency meter: FSM state encoding
// and default measurement constants also used by the RO top level.
`timescale 1ns/1ps
package ro_meter_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ARM     = 2'd1;
  localparam logic [1:0] ST_MEASURE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    ARM     = ST_ARM,
    MEASURE = ST_MEASURE,
    DONE    = ST_DONE
  } meter_state_e;

  localparam int DEF_WINDOW      = 1024;
  localparam int DEF_SETTLE      = 16;
  localparam int DEF_PRESC       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/ro_edge_sync.sv
// Prescales the free-running oscillator in its own domain, carries the prescaler MSB
// into CLK through a synchronizer, and emits a one-CLK pulse per rising MSB edge.
`timescale 1ns/1ps
module ro_edge_sync
  import ro_meter_pkg::*;
#(
  parameter int PRESC       = DEF_PRESC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ro_clk,
  output logic event_pulse
);

  logic [PRESC-1:0] presc_reg;

  always_ff @(posedge ro_clk or posedge RESET) begin
    if (RESET) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + PRESC'(1);
    end
  end

  // Only the MSB crosses domains; it toggles slowly enough to be sampled cleanly.
  (* ASYNC_REG = "TRUE", KEEP = "TRUE" *) logic [SYNC_STAGES-1:0] sync_reg;
  logic prev_reg;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_reg <= '0;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], presc_reg[PRESC-1]};
      prev_reg <= sync_reg[SYNC_STAGES-1];
    end
  end

  assign event_pulse = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/ro_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, lets it settle, counts
// prescaled edges over a fixed CLK window and reports the count with a valid strobe.
`timescale 1ns/1ps
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int WINDOW      = DEF_WINDOW,
  parameter int SETTLE      = DEF_SETTLE,
  parameter int PRESC       = DEF_PRESC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             start,
  input  logic             ro_clk,
  output logic             ro_enable,
  output logic             busy,
  output logic             count_valid,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int TMR_W   = (TMR_MAX > 2) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE - 1);
  localparam logic [TMR_W-1:0] WINDOW_LAST = TMR_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  logic event_pulse;

  ro_edge_sync #(
    .PRESC       (PRESC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .CLK         (CLK),
    .RESET       (RESET),
    .ro_clk      (ro_clk),
    .event_pulse (event_pulse)
  );

  meter_state_e     state_reg, state_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             ovf_reg, ovf_next;
  logic             ro_enable_reg, busy_reg, count_valid_reg, overflow_reg;
  logic [CNT_W-1:0] count_reg;

  always_comb begin
    state_next = state_reg;
    timer_next = timer_reg;
    cnt_next   = cnt_reg;
    ovf_next   = ovf_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ARM;
          timer_next = SETTLE_LAST;
        end
      end
      ARM: begin
        // Settling edges are discarded; the count starts clean on the first MEASURE cycle.
        if (timer_reg == '0) begin
          state_next = MEASURE;
          timer_next = WINDOW_LAST;
          cnt_next   = '0;
          ovf_next   = 1'b0;
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end
      MEASURE: begin
        if (event_pulse) begin
          if (cnt_reg == CNT_MAX) begin
            ovf_next = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        if (timer_reg == '0) begin
          state_next = DONE;
        end else begin
          timer_next = timer_reg - TMR_W'(1);
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_reg       <= IDLE;
      timer_reg       <= '0;
      cnt_reg         <= '0;
      ovf_reg         <= 1'b0;
      ro_enable_reg   <= 1'b0;
      busy_reg        <= 1'b0;
      count_valid_reg <= 1'b0;
      count_reg       <= '0;
      overflow_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      timer_reg       <= timer_next;
      cnt_reg         <= cnt_next;
      ovf_reg         <= ovf_next;
      // Enable is a bare flop output so nothing sits in front of the oscillator.
      ro_enable_reg   <= (state_next == ARM) || (state_next == MEASURE);
      busy_reg        <= (state_next != IDLE);
      count_valid_reg <= (state_reg == DONE);
      if (state_reg == DONE) begin
        count_reg    <= cnt_reg;
        overflow_reg <= ovf_reg;
      end
    end
  end

  assign ro_enable   = ro_enable_reg;
  assign busy        = busy_reg;
  assign count_valid = count_valid_reg;
  assign count       = count_reg;
  assign overflow    = overflow_reg;

endmodule
